// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator scheduler.
// Contents: floor count and index width, direction encodings, FSM state
// encoding, and a helper that sizes the cycle timers.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 16;
  localparam int unsigned FLOOR_W    = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    ARRIVE    = 3'd3,
    DOOR_OPEN = 3'd4,
    HALT      = 3'd5
  } state_t;

  // Width needed to hold (cycles-1). A one-cycle timer still uses one bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/elev_cycle_timer.sv
// Load/expire down-counter used to time floor travel and door dwell.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   load        - reload the counter with load_value (has priority)
//   load_value  - reload value (cycles - 1)
//   run         - decrement by one each cycle while nonzero
//   expired     - high while the count is zero
module elev_cycle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/elevator_scan_scheduler.sv
// LOOK request scheduler for the elevator: latches button presses into a
// pending bitmap, keeps travelling in the current direction while requests
// remain ahead, then reverses. Times floor travel and door dwell, and drives
// the external floor counter.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   floor_buttons     - level button inputs, bit n requests floor n
//   current_floor     - floor counter value
//   count_enable      - combinational one-cycle step pulse to the counter
//   up_down           - counter direction, 1 = up
//   door_open         - high while the door is open
//   moving            - high while travelling or arriving
//   pending_requests  - registered pending-request bitmap
//   estop             - emergency stop (only when ELEV_ESTOP_EN is defined)
// Optional feature macro: ELEV_ESTOP_EN adds the estop input and HALT state.
module elevator_scan_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor_buttons,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  count_enable,
  output logic                  up_down,
  output logic                  door_open,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending_requests
`ifdef ELEV_ESTOP_EN
  ,
  input  logic                  estop
`endif
);

  localparam int unsigned TRAVEL_W = timer_width(TRAVEL_CYCLES);
  localparam int unsigned DWELL_W  = timer_width(DWELL_CYCLES);

  state_t                state, next_state;
  logic                  dir, next_dir;
  logic [NUM_FLOORS-1:0] pending, clr;
  logic                  above, below, pend_here, at_limit, ahead;
  logic                  travel_load, travel_expired;
  logic                  dwell_load, dwell_expired;

  // Request-priority terms relative to the current floor.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > 32'(current_floor))) above = 1'b1;
      if (pending[i] && (i < 32'(current_floor))) below = 1'b1;
    end
  end

  assign pend_here = pending[current_floor];
  assign ahead     = (dir == DIR_UP) ? above : below;
  assign at_limit  = (dir == DIR_UP) ? (current_floor == FLOOR_W'(NUM_FLOORS - 1))
                                     : (current_floor == '0);

  // The served floor is cleared only while the door is open; a press of that
  // floor in the same cycle therefore never sets its bit.
  assign clr = (state == DOOR_OPEN) ? (NUM_FLOORS'(1) << current_floor) : '0;

  elev_cycle_timer #(.WIDTH(TRAVEL_W)) u_travel_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (travel_load),
    .load_value (TRAVEL_W'(TRAVEL_CYCLES - 1)),
    .run        ((state == MOVE_UP) || (state == MOVE_DOWN)),
    .expired    (travel_expired)
  );

  elev_cycle_timer #(.WIDTH(DWELL_W)) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (dwell_load),
    .load_value (DWELL_W'(DWELL_CYCLES - 1)),
    .run        (state == DOOR_OPEN),
    .expired    (dwell_expired)
  );

  // State, direction, pending bitmap and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      pending   <= '0;
      door_open <= 1'b0;
      moving    <= 1'b0;
    end else begin
      state     <= next_state;
      dir       <= next_dir;
      pending   <= (pending | floor_buttons) & ~clr;
      door_open <= (next_state == DOOR_OPEN);
      moving    <= (next_state == MOVE_UP) || (next_state == MOVE_DOWN) ||
                   (next_state == ARRIVE);
    end
  end

  // Next-state logic and counter step pulse.
  always_comb begin
    next_state   = state;
    next_dir     = dir;
    count_enable = 1'b0;
    travel_load  = 1'b0;
    dwell_load   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_here) begin
          next_state = DOOR_OPEN;
          dwell_load = 1'b1;
        end else if (above && ((dir == DIR_UP) || !below)) begin
          next_state  = MOVE_UP;
          next_dir    = DIR_UP;
          travel_load = 1'b1;
        end else if (below) begin
          next_state  = MOVE_DOWN;
          next_dir    = DIR_DOWN;
          travel_load = 1'b1;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_expired) begin
          // A step past either end can only come from corrupt feedback.
          if (at_limit) begin
            next_state = IDLE;
          end else begin
            count_enable = 1'b1;
            next_state   = ARRIVE;
          end
        end
      end
      ARRIVE: begin
        if (pend_here) begin
          next_state = DOOR_OPEN;
          dwell_load = 1'b1;
        end else if (ahead) begin
          next_state  = (dir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
          travel_load = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      DOOR_OPEN: begin
        // Pressing the open floor keeps the door open for a full dwell.
        if (floor_buttons[current_floor]) begin
          dwell_load = 1'b1;
        end else if (dwell_expired) begin
          next_state = IDLE;
        end
      end
`ifdef ELEV_ESTOP_EN
      HALT: begin
        if (!estop) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
`ifdef ELEV_ESTOP_EN
    // Any in-flight step pulse this cycle still reaches the counter.
    if (estop) next_state = HALT;
`endif
  end

  assign up_down          = dir;
  assign pending_requests = pending;

endmodule
